// File: rtl/run_controller.sv
// run_controller: owns execution of the accumulator CPU.
// It clears the CPU, runs it either freely or one instruction per step
// request, and stops when the HLT opcode is presented. It then reports the
// executed-cycle count, followed by the first DUMP_WORDS data-memory words,
// over a byte-wide valid/ready transmit handshake.
//
// Output timing:
//   - All outputs are Moore-style decodes of the state and of registered
//     data, except cpu_en and cpu_reset.
//   - cpu_en also depends on opcode, so a HLT is never executed.
//   - cpu_reset also follows reset directly.
//   - tx_valid never depends on tx_ready.
//
// Dump read timing:
//   - dm_addr is a register that holds the word index, and dm_sel is high
//     in DUMP_RD.
//   - The memory word for that index is captured on the clock edge that
//     leaves DUMP_RD. Data is then served from that register while the two
//     bytes are sent.
//   - Only DATA_LENGTH == 16 is meaningful: every word is sent as exactly
//     two bytes.

module run_controller #(
  parameter int ADDR_LENGTH   = 11,
  parameter int DATA_LENGTH   = 16,
  parameter int OPCODE_LENGTH = 5,
  parameter int HLT_OPCODE    = 0,
  parameter int DUMP_WORDS    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     step,
  input  logic                     step_mode,
  input  logic [OPCODE_LENGTH-1:0] opcode,
  input  logic [DATA_LENGTH-1:0]   data_from_dm,
  input  logic                     tx_ready,
  output logic                     cpu_en,
  output logic                     cpu_reset,
  output logic                     dm_sel,
  output logic [ADDR_LENGTH-1:0]   dm_addr,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  output logic                     halted,
  output logic [15:0]              cycle_count
);

  // ---------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------
  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] CLEAR     = 4'd1;
  localparam logic [3:0] RUN       = 4'd2;
  localparam logic [3:0] PAUSE     = 4'd3;
  localparam logic [3:0] STEP      = 4'd4;
  localparam logic [3:0] TX_CNT_LO = 4'd5;
  localparam logic [3:0] TX_CNT_HI = 4'd6;
  localparam logic [3:0] DUMP_RD   = 4'd7;
  localparam logic [3:0] DUMP_LO   = 4'd8;
  localparam logic [3:0] DUMP_HI   = 4'd9;
  localparam logic [3:0] DONE      = 4'd10;

  localparam logic [OPCODE_LENGTH-1:0] HLT_OP   = OPCODE_LENGTH'(HLT_OPCODE);
  localparam logic [ADDR_LENGTH-1:0]   LAST_IDX = ADDR_LENGTH'(DUMP_WORDS - 1);
  localparam logic [15:0]              CNT_MAX  = 16'hFFFF;

  // ---------------------------------------------------------------------
  // Registers and internal decodes
  // ---------------------------------------------------------------------
  logic [3:0]             state;
  logic [3:0]             state_nxt;
  logic [ADDR_LENGTH-1:0] word_idx;
  logic [DATA_LENGTH-1:0] dump_word;

  logic is_hlt;
  logic last_word;
  logic byte_taken;
  logic in_dump;
  logic in_tx;

  assign is_hlt    = (opcode == HLT_OP);
  assign last_word = (word_idx == LAST_IDX);

  // A byte leaves this block only on a cycle with both valid and ready.
  assign byte_taken = tx_valid && tx_ready;

  assign in_dump = (state == DUMP_RD) || (state == DUMP_LO) ||
                   (state == DUMP_HI);

  assign in_tx   = (state == TX_CNT_LO) || (state == TX_CNT_HI) ||
                   (state == DUMP_LO)   || (state == DUMP_HI);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // Sequencing decisions. Each request is only honoured in the states that
  // sample it: start in IDLE/DONE, step in PAUSE, step_mode in CLEAR.
  always_comb begin
    // NOTE: a default assignment at the top of every combinational block
    // keeps every path assigned, so no latch can be inferred.
    state_nxt = state;

    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = CLEAR;
      end

      CLEAR: begin
        state_nxt = step_mode ? PAUSE : RUN;
      end

      RUN: begin
        if (is_hlt) state_nxt = TX_CNT_LO;
      end

      // A halt takes priority over a pending step request.
      PAUSE: begin
        if (is_hlt)    state_nxt = TX_CNT_LO;
        else if (step) state_nxt = STEP;
      end

      // Always returns to PAUSE. A held step therefore costs one PAUSE
      // cycle per executed instruction.
      STEP: begin
        state_nxt = PAUSE;
      end

      TX_CNT_LO: begin
        if (tx_ready) state_nxt = TX_CNT_HI;
      end

      TX_CNT_HI: begin
        if (tx_ready) state_nxt = DUMP_RD;
      end

      DUMP_RD: begin
        state_nxt = DUMP_LO;
      end

      DUMP_LO: begin
        if (tx_ready) state_nxt = DUMP_HI;
      end

      DUMP_HI: begin
        if (tx_ready) state_nxt = last_word ? DONE : DUMP_RD;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------
  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Executed-cycle counter: cleared on entry to CLEAR, saturating at
  // 0xFFFF.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
    end else if ((state_nxt == CLEAR) && (state != CLEAR)) begin
      cycle_count <= '0;
    end else if (cpu_en && (cycle_count != CNT_MAX)) begin
      cycle_count <= cycle_count + 16'd1;
    end
  end

  // Dump word index: rewinds once the count bytes are sent, and advances
  // after each high byte is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_idx <= '0;
    end else if ((state == TX_CNT_HI) && tx_ready) begin
      word_idx <= '0;
    end else if ((state == DUMP_HI) && tx_ready && !last_word) begin
      word_idx <= word_idx + ADDR_LENGTH'(1);
    end
  end

  // Capture the addressed memory word when leaving DUMP_RD. It is held
  // stable for both bytes, even under backpressure.
  always_ff @(posedge clk) begin
    if (reset)                  dump_word <= '0;
    else if (state == DUMP_RD)  dump_word <= data_from_dm;
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // cpu_en is combinational on opcode: a HLT in RUN is never executed.
  assign cpu_en    = ((state == RUN) && !is_hlt) || (state == STEP);
  assign cpu_reset = reset || (state == CLEAR);
  assign dm_sel    = in_dump;
  assign dm_addr   = word_idx;
  assign tx_valid  = in_tx;
  assign halted    = (state == DONE);

  // Byte selection for the transmitter. The result is zero outside the
  // transmit states.
  always_comb begin
    tx_data = 8'h00;

    case (state)
      TX_CNT_LO: tx_data = cycle_count[7:0];
      TX_CNT_HI: tx_data = cycle_count[15:8];
      DUMP_LO:   tx_data = dump_word[7:0];
      DUMP_HI:   tx_data = dump_word[15:8];
      default:   tx_data = 8'h00;
    endcase
  end

endmodule

// File: doc/run_controller.md
# run_controller

Sequencer that owns execution of the accumulator CPU: starts it from a clean state, runs it freely or one instruction per step request, detects the HLT opcode, then reports the result over a byte-wide transmit handshake. Sits between the debug/UART transmitter and the cpu + data memory. It gates the CPU with an enable, counts executed cycles, and takes over the data-memory read address after halt to dump the first DUMP_WORDS words.

## Interface
- ADDR_LENGTH, 11, data-memory address width
- DATA_LENGTH, 16, data word width; only 16 supported (two bytes per word)
- OPCODE_LENGTH, 5, opcode width
- HLT_OPCODE, 0, opcode value treated as halt
- DUMP_WORDS, 8, words dumped from data memory address 0 upward (1..2^ADDR_LENGTH)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE
- start  in  1  run request, sampled in IDLE and DONE only
- step  in  1  single-step request, sampled in PAUSE only
- step_mode  in  1  1 = single-step execution; sampled only in CLEAR
- opcode  in  OPCODE_LENGTH  opcode of instruction currently presented to the cpu
- data_from_dm  in  DATA_LENGTH  data-memory read data, valid one cycle after address
- tx_ready  in  1  transmitter accepts byte this cycle
- cpu_en  out  1  cpu advances this cycle
- cpu_reset  out  1  reset to cpu = reset OR (state == CLEAR)
- dm_sel  out  1  1 = dm_addr drives data-memory address instead of cpu
- dm_addr  out  ADDR_LENGTH  dump read address
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid
- halted  out  1  high in DONE
- cycle_count  out  16  executed cycles, saturating at 0xFFFF

## Operation
- States: IDLE, CLEAR, RUN, PAUSE, STEP, TX_CNT_LO, TX_CNT_HI, DUMP_RD, DUMP_LO, DUMP_HI, DONE.
- IDLE/DONE: start -> CLEAR; cycle_count cleared on entering CLEAR.
- CLEAR (1 cycle): cpu_reset high; -> PAUSE if step_mode else RUN.
- RUN: cpu_en = (opcode != HLT_OPCODE); if opcode == HLT_OPCODE -> TX_CNT_LO. HLT never executes; PC stays on it.
- PAUSE: cpu_en 0; opcode == HLT_OPCODE -> TX_CNT_LO (priority over step); else step -> STEP.
- STEP (1 cycle): cpu_en 1; -> PAUSE. Held-high step yields one step per PAUSE->STEP pair (every 2 cycles).
- cycle_count increments each cycle cpu_en is 1, saturates.
- TX_CNT_LO / TX_CNT_HI: tx_data = cycle_count[7:0] / [15:8], tx_valid 1; advance on tx_ready.
- DUMP_RD: dm_sel 1, dm_addr = word index (starts 0); -> DUMP_LO next cycle; data_from_dm latched on that entry.
- DUMP_LO / DUMP_HI: send latched word low byte then high byte; after HI accepted: index == DUMP_WORDS-1 -> DONE, else index+1 -> DUMP_RD.
- dm_sel 1 in DUMP_RD, DUMP_LO, DUMP_HI; 0 elsewhere.
- start ignored outside IDLE/DONE; step ignored outside PAUSE; step_mode changes outside CLEAR have no effect.

## Timing
- Reset values: state IDLE, cpu_en 0, cpu_reset 1 (while reset), dm_sel 0, dm_addr 0, tx_data 0, tx_valid 0, halted 0, cycle_count 0.
- start high in cycle n (IDLE) -> CLEAR in n+1 (cpu_reset 1) -> RUN in n+2, cpu_en 1 from n+2.
- HLT visible in cycle m in RUN -> cpu_en 0 in m (combinational), tx_valid 1 from m+1.
- tx handshake: tx_valid and tx_data held stable until cycle with tx_valid && tx_ready; byte transferred that cycle; next byte no earlier than following cycle. tx_valid never depends combinationally on tx_ready.
- Dump word cost: 1 read cycle + 2 accepted bytes; with tx_ready tied 1, 3 cycles per word.
- reset mid-operation (any state, including mid-byte): next cycle all outputs at reset values; no partial byte completion.
- start and step both high in IDLE: start taken, step ignored.

## Test plan
- Free run: step_mode 0, program of 5 non-HLT instructions then HLT, tx_ready 1 -> cpu_en high 5 cycles, bytes 0x05, 0x00, then 16 dump bytes low/high order, halted 1.
- Step mode: step_mode 0->1 before start, pulse step 3 times with gaps -> exactly 3 single-cycle cpu_en pulses, cycle_count 3; HLT at 4th instruction -> TX_CNT_LO without step.
- Backpressure: tx_ready low 4 cycles during DUMP_LO with DM[0]=0xBEEF -> tx_data 0xEF, tx_valid held stable 4 cycles, then 0xBE; no byte lost/duplicated.
- Immediate HLT: opcode = HLT_OPCODE on first RUN cycle -> cpu_en never 1, count bytes 0x00 0x00.
- Saturation: 70000 non-HLT cycles -> cycle_count 0xFFFF, bytes 0xFF 0xFF.
- reset asserted in DUMP_HI of word 3 -> next cycle IDLE, tx_valid 0, dm_sel 0; new start repeats full sequence from word 0.
